// File: rtl/kpn_fifo_channel.sv
// kpn_fifo_channel
//   Bounded FIFO channel feeding one adder operand in the KPN datapath.
//   The channel accepts only well-formed fixed-point tokens
//   ([15:4] integer, [3:0] decimal digit 0..9), tracks occupancy and
//   records protocol violations.
//
// Ports
//   clk       in   rising-edge clock
//   reset_n   in   synchronous active-low reset
//   wr        in   push request
//   data_in   in   token to push
//   rd        in   pop request
//   data_out  out  registered head token from the last accepted pop
//   full      out  count == DEPTH
//   empty     out  count == 0
//   count     out  occupancy 0..DEPTH
//   fmt_err   out  one-cycle pulse: push dropped for a bad decimal digit
//   drop_cnt  out  saturating count of format-rejected pushes
//   ovf_err   out  sticky: valid push refused because channel was full
//   unf_err   out  sticky: pop refused because channel was empty
module kpn_fifo_channel #(
  parameter int ADDR_W = 3,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              wr,
  input  logic [DATA_W-1:0] data_in,
  input  logic              rd,
  output logic [DATA_W-1:0] data_out,
  output logic              full,
  output logic              empty,
  output logic [ADDR_W:0]   count,
  output logic              fmt_err,
  output logic [7:0]        drop_cnt,
  output logic              ovf_err,
  output logic              unf_err
);

  localparam int              DEPTH   = 1 << ADDR_W;
  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);

  // Storage carries no reset; its contents are don't-care until written.
  logic [DEPTH-1:0][DATA_W-1:0] mem_q;

  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   count_q,  count_d;
  logic [DATA_W-1:0] dout_q,   dout_d;
  logic [7:0]        drop_q,   drop_d;
  logic              fmt_q,    fmt_d;
  logic              ovf_q,    ovf_d;
  logic              unf_q,    unf_d;

  logic full_w, empty_w, valid_fmt, rd_ok, wr_ok;

  // Flags come from the registered count, never from a pointer compare.
  assign full_w    = (count_q == DEPTH_C);
  assign empty_w   = (count_q == '0);
  assign valid_fmt = (data_in[3:0] <= 4'd9);
  assign rd_ok     = rd && !empty_w;
  // A full channel still takes a push when a pop frees a slot this cycle.
  assign wr_ok     = wr && valid_fmt && (!full_w || rd_ok);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    dout_d   = dout_q;
    drop_d   = drop_q;
    fmt_d    = 1'b0;
    ovf_d    = ovf_q;
    unf_d    = unf_q;

    if (wr_ok) wr_ptr_d = wr_ptr_q + 1'b1;

    if (rd_ok) begin
      dout_d   = mem_q[rd_ptr_q];
      rd_ptr_d = rd_ptr_q + 1'b1;
    end

    case ({wr_ok, rd_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    // Format drops never count as overflow, even when full.
    if (wr && !valid_fmt) begin
      fmt_d = 1'b1;
      if (drop_q != 8'hFF) drop_d = drop_q + 8'd1;
    end

    if (wr && valid_fmt && full_w && !rd_ok) ovf_d = 1'b1;
    if (rd && empty_w)                       unf_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      dout_q   <= '0;
      drop_q   <= '0;
      fmt_q    <= 1'b0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      dout_q   <= dout_d;
      drop_q   <= drop_d;
      fmt_q    <= fmt_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset_n && wr_ok) mem_q[wr_ptr_q] <= data_in;
  end

  assign data_out = dout_q;
  assign full     = full_w;
  assign empty    = empty_w;
  assign count    = count_q;
  assign fmt_err  = fmt_q;
  assign drop_cnt = drop_q;
  assign ovf_err  = ovf_q;
  assign unf_err  = unf_q;

endmodule
